// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline stage chain.
package pipe_pkg;

   localparam int unsigned DEPTH_MAX = 4;

   // Bits needed to hold a live-slot count in the range 0..depth.
   function automatic int unsigned count_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the stage chain: a valid flag plus payload, with
// load from the slot behind it and an in-place kill.
module pipe_slot #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             take,
   input  logic             src_valid,
   input  logic [WIDTH-1:0] src_data,
   input  logic             kill,
   output logic             valid_next_c,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // When taking, the current occupant has left, so its kill is applied downstream.
   always_comb begin
      valid_next_c = valid & ~kill;
      if (take) valid_next_c = src_valid;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         valid <= valid_next_c;
         if (take && src_valid) data <= src_data;
      end
   end

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain of DEPTH slots with bubble collapse
// and per-slot flush; slot DEPTH-1 is the oldest and drives the output.
module pipe_stage_chain
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [WIDTH-1:0]            in_data,
   output logic                        in_ready,
   output logic                        out_valid,
   output logic [WIDTH-1:0]            out_data,
   input  logic                        out_ready,
   input  logic                        flush_in,
   input  logic [DEPTH-1:0]            flush_mask,
   output logic [count_w(DEPTH)-1:0]   count
);

   localparam int unsigned CNT_W = count_w(DEPTH);

   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] valid_next;
   logic [DEPTH-1:0] ready;
   logic [DEPTH-1:0] src_valid;
   logic [WIDTH-1:0] data     [DEPTH];
   logic [WIDTH-1:0] src_data [DEPTH];
   logic [CNT_W-1:0] count_next;

   // Slot i may take a new entry unless it and every slot ahead are full and the output stalls.
   always_comb begin : ready_chain
      logic full_ahead;
      full_ahead = 1'b1;
      ready      = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         full_ahead = full_ahead & valid[i];
         ready[i]   = out_ready | ~full_ahead;
      end
   end

   // Flushed entries travel as empty bubbles into their destination slot.
   always_comb begin : source_select
      src_valid    = '0;
      src_valid[0] = in_valid & ~flush_in;
      src_data[0]  = in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
         src_valid[i] = valid[i-1] & ~flush_mask[i-1];
         src_data[i]  = data[i-1];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      pipe_slot #(.WIDTH(WIDTH)) u_slot (
         .clk          (clk),
         .reset        (reset),
         .take         (ready[g]),
         .src_valid    (src_valid[g]),
         .src_data     (src_data[g]),
         .kill         (flush_mask[g]),
         .valid_next_c (valid_next[g]),
         .valid        (valid[g]),
         .data         (data[g])
      );
   end

   always_comb begin : popcount
      count_next = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         count_next = count_next + CNT_W'(valid_next[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count <= '0;
      else        count <= count_next;
   end

   assign in_ready  = ready[0];
   assign out_valid = valid[DEPTH-1];
   assign out_data  = data[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: three chains (DEPTH 2, 3, 4) checked against an
// entry-list model every cycle, plus directed literal expectations.
module tb_pipe_stage_chain;

   logic        clk = 1'b0;
   logic        reset;
   logic        iv   [3];
   logic [15:0] idat [3];
   logic        ordy [3];
   logic        fin  [3];
   logic [3:0]  fm   [3];
   logic        ir   [3];
   logic        ov   [3];
   logic [15:0] od   [3];
   logic [1:0]  c2;
   logic [1:0]  c3;
   logic [2:0]  c4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_chain #(.WIDTH(16), .DEPTH(2)) u_d2 (
      .clk(clk), .reset(reset), .in_valid(iv[0]), .in_data(idat[0]), .in_ready(ir[0]),
      .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]), .flush_in(fin[0]),
      .flush_mask(fm[0][1:0]), .count(c2));

   pipe_stage_chain #(.WIDTH(16), .DEPTH(3)) u_d3 (
      .clk(clk), .reset(reset), .in_valid(iv[1]), .in_data(idat[1]), .in_ready(ir[1]),
      .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]), .flush_in(fin[1]),
      .flush_mask(fm[1][2:0]), .count(c3));

   pipe_stage_chain #(.WIDTH(16), .DEPTH(4)) u_d4 (
      .clk(clk), .reset(reset), .in_valid(iv[2]), .in_data(idat[2]), .in_ready(ir[2]),
      .out_valid(ov[2]), .out_data(od[2]), .out_ready(ordy[2]), .flush_in(fin[2]),
      .flush_mask(fm[2][3:0]), .count(c4));

   // Model: per chain, a list of live entries (oldest first) with slot positions.
   int          mn    [3];
   logic [15:0] md    [3][4];
   int          mp    [3][4];
   logic [15:0] mlast [3];
   int          tn, tpos, tnew, prev_new;
   logic [15:0] td [5];
   int          tp [5];
   bit          tin;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] cnt_act(input int k);
      case (k)
         0:       return 32'(c2);
         1:       return 32'(c3);
         default: return 32'(c4);
      endcase
   endfunction

   task automatic model_clear;
      for (int k = 0; k < 3; k++) begin
         mn[k]    = 0;
         mlast[k] = '0;
      end
   endtask

   // Each entry moves one position toward the output unless the entry ahead stayed put.
   task automatic model_step;
      for (int k = 0; k < 3; k++) begin
         tin      = ordy[k] || (mn[k] < k + 2);
         tn       = 0;
         prev_new = -1;
         for (int e = 0; e < mn[k]; e++) begin
            tpos = mp[k][e];
            if (tpos == k + 1)              tnew = ordy[k] ? k + 2 : tpos;
            else if (prev_new == tpos + 1)  tnew = tpos;
            else                            tnew = tpos + 1;
            prev_new = tnew;
            if (!fm[k][tpos] && tnew <= k + 1) begin
               td[tn] = md[k][e];
               tp[tn] = tnew;
               tn++;
            end
         end
         if (iv[k] && tin && !fin[k]) begin
            td[tn] = idat[k];
            tp[tn] = 0;
            tn++;
         end
         mn[k] = tn;
         for (int e = 0; e < tn; e++) begin
            md[k][e] = td[e];
            mp[k][e] = tp[e];
         end
         if (tn > 0 && tp[0] == k + 1) mlast[k] = td[0];
      end
   endtask

   task automatic compare_all;
      bit eov;
      bit eir;
      for (int k = 0; k < 3; k++) begin
         eov = (mn[k] > 0) && (mp[k][0] == k + 1);
         eir = ordy[k] || (mn[k] < k + 2);
         chk($sformatf("model out_valid d%0d", k + 2), 32'(ov[k]), 32'(eov));
         chk($sformatf("model out_data d%0d", k + 2),  32'(od[k]), 32'(mlast[k]));
         chk($sformatf("model count d%0d", k + 2),     cnt_act(k), 32'(mn[k]));
         chk($sformatf("model in_ready d%0d", k + 2),  32'(ir[k]), 32'(eir));
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) model_clear();
      else        model_step();
   end

   always @(negedge clk) compare_all();

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; idat[k] = '0; ordy[k] = 1'b1; fin[k] = 1'b0; fm[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("reset out_valid", 32'(ov[k]), 32'd0);
         chk("reset count",     cnt_act(k), 32'd0);
         chk("reset out_data",  32'(od[k]), 32'd0);
         chk("reset in_ready",  32'(ir[k]), 32'd1);
      end
      reset = 1'b1;
      tick();

      // Stream through DEPTH=3.
      for (int n = 1; n <= 13; n++) begin
         iv[1]   = (n <= 10);
         idat[1] = 16'(n);
         tick();
         if (n >= 3 && n <= 12) begin
            chk("stream out_valid", 32'(ov[1]), 32'd1);
            chk("stream out_data",  32'(od[1]), 32'(n - 2));
         end
         if (n >= 3 && n <= 10) chk("stream count", cnt_act(1), 32'd3);
         if (n == 13) chk("stream drained", 32'(ov[1]), 32'd0);
      end
      iv[1] = 1'b0;

      // Backpressure on DEPTH=2.
      ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = 16'hAA;
      tick();
      idat[0] = 16'hBB;
      tick();
      iv[0] = 1'b0;
      repeat (5) begin
         tick();
         chk("bp in_ready",  32'(ir[0]), 32'd0);
         chk("bp count",     cnt_act(0), 32'd2);
         chk("bp out_data",  32'(od[0]), 32'hAA);
      end
      ordy[0] = 1'b1;
      #1;
      chk("bp release in_ready", 32'(ir[0]), 32'd1);
      chk("bp release first",    32'(od[0]), 32'hAA);
      tick();
      chk("bp second data",  32'(od[0]), 32'hBB);
      chk("bp second valid", 32'(ov[0]), 32'd1);
      tick();
      chk("bp empty valid", 32'(ov[0]), 32'd0);
      chk("bp held data",   32'(od[0]), 32'hBB);

      // Bubble collapse on DEPTH=4.
      ordy[2] = 1'b0; iv[2] = 1'b1; idat[2] = 16'h55;
      tick();
      iv[2] = 1'b0;
      tick(); tick();
      chk("bubble not yet out", 32'(ov[2]), 32'd0);
      tick();
      chk("bubble arrived valid", 32'(ov[2]), 32'd1);
      chk("bubble arrived data",  32'(od[2]), 32'h55);
      chk("bubble count one",     cnt_act(2), 32'd1);
      iv[2] = 1'b1; idat[2] = 16'h66;
      tick();
      iv[2] = 1'b0;
      tick(); tick(); tick();
      chk("bubble second count", cnt_act(2), 32'd2);
      chk("bubble in_ready",     32'(ir[2]), 32'd1);
      iv[2] = 1'b1; idat[2] = 16'h77;
      tick();
      idat[2] = 16'h88;
      tick();
      iv[2] = 1'b0;
      chk("bubble full count",    cnt_act(2), 32'd4);
      chk("bubble full in_ready", 32'(ir[2]), 32'd0);
      ordy[2] = 1'b1;
      #1;
      chk("bubble release in_ready", 32'(ir[2]), 32'd1);
      chk("bubble drain 55", 32'(od[2]), 32'h55);
      tick(); chk("bubble drain 66", 32'(od[2]), 32'h66);
      tick(); chk("bubble drain 77", 32'(od[2]), 32'h77);
      tick(); chk("bubble drain 88", 32'(od[2]), 32'h88);
      tick(); chk("bubble drained",  32'(ov[2]), 32'd0);

      // Selective flush on DEPTH=3.
      ordy[1] = 1'b0; iv[1] = 1'b1; idat[1] = 16'h1;
      tick();
      idat[1] = 16'h2;
      tick();
      idat[1] = 16'h3;
      tick();
      iv[1] = 1'b0;
      chk("flush full count",    cnt_act(1), 32'd3);
      chk("flush full in_ready", 32'(ir[1]), 32'd0);
      fm[1] = 4'b0010;
      tick();
      fm[1] = 4'b0000;
      chk("flush count",    cnt_act(1), 32'd2);
      chk("flush oldest",   32'(od[1]), 32'h1);
      chk("flush in_ready", 32'(ir[1]), 32'd1);
      tick();
      chk("flush hold count", cnt_act(1), 32'd2);
      ordy[1] = 1'b1;
      #1;
      chk("flush order first", 32'(od[1]), 32'h1);
      tick();
      chk("flush order second", 32'(od[1]), 32'h3);
      chk("flush second valid", 32'(ov[1]), 32'd1);
      tick();
      chk("flush drained", 32'(ov[1]), 32'd0);

      // flush_in consumes the input without storing it.
      iv[1] = 1'b1; fin[1] = 1'b1; idat[1] = 16'hDEAD;
      #1;
      chk("flush_in in_ready", 32'(ir[1]), 32'd1);
      tick();
      iv[1] = 1'b0; fin[1] = 1'b0;
      chk("flush_in count", cnt_act(1), 32'd0);
      repeat (4) begin
         tick();
         chk("flush_in no valid", 32'(ov[1]), 32'd0);
         chk("flush_in no dead",  32'(od[1]), 32'h3);
      end

      // Asynchronous reset mid-stream.
      ordy[1] = 1'b0; iv[1] = 1'b1; idat[1] = 16'h11;
      tick();
      idat[1] = 16'h22;
      tick();
      idat[1] = 16'h33;
      tick();
      iv[1] = 1'b0;
      chk("rst pre count", cnt_act(1), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      chk("rst async out_valid", 32'(ov[1]), 32'd0);
      chk("rst async count",     cnt_act(1), 32'd0);
      chk("rst async in_ready",  32'(ir[1]), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      ordy[1] = 1'b1; iv[1] = 1'b1; idat[1] = 16'h7;
      tick();
      iv[1] = 1'b0;
      chk("rst fresh lat1", 32'(ov[1]), 32'd0);
      tick();
      chk("rst fresh lat2", 32'(ov[1]), 32'd0);
      tick();
      chk("rst fresh valid", 32'(ov[1]), 32'd1);
      chk("rst fresh data",  32'(od[1]), 32'h7);
      tick();
      chk("rst fresh gone", 32'(ov[1]), 32'd0);

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
